// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
//   tx_state_t : transmit FSM state encoding
//   PAR_EVEN/PAR_ODD : parity sense values for the ohel input
//   KMIN : smallest usable bit period in clk cycles
//   parity_bit : parity of the data bits actually sent, folded with ohel
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int KMIN = 2;

  // Bit 7 does not take part in 7-bit frames, so it is masked off first.
  function automatic logic parity_bit(input logic [7:0] d,
                                      input logic       eight,
                                      input logic       ohel);
    logic [7:0] m;
    m = eight ? d : {1'b0, d[6:0]};
    return (^m) ^ (ohel == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk, rst   : clock, synchronous active-low reset
//   push, din  : write strobe and data; dropped when full unless a pop
//                happens in the same cycle
//   pop, dout  : read strobe (ignored when empty) and head-of-queue data
//   full, empty, count : occupancy status
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop;
  logic w_push;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // When full, a same-cycle pop frees the slot the push will use.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: write-strobed FIFO feeding a framing FSM with
// 7/8 data bits, optional parity and 1/2 stop bits, plus TXRDY interrupt
// and sticky overflow flags.
//   clk, rst         : clock, synchronous active-low reset
//   write, din       : push strobe and byte
//   eight, pen, ohel, stop2 : frame format, latched at frame start
//   k                : bit period in clk cycles (values below 2 act as 2)
//   int_ack, clr_err : clear interrupt / overflow (set wins on collision)
//   tx               : serial line, idles high
//   txrdy, fifo_empty, fifo_count, busy, interrupt, overflow : status
//
// state  | meaning
// IDLE   | line high; pops the FIFO head whenever it is non-empty
// START  | start bit (low) for keff cycles
// DATA   | data bits LSB first, 7 or 8 of them
// PARITY | parity bit, only when pen was set at frame start
// STOP1  | first stop bit (high)
// STOP2  | second stop bit, only when stop2 was set at frame start
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int K_WIDTH    = 19,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic [7:0]         din,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  input  logic               stop2,
  input  logic [K_WIDTH-1:0] k,
  input  logic               int_ack,
  input  logic               clr_err,
  output logic               tx,
  output logic               txrdy,
  output logic               fifo_empty,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               busy,
  output logic               interrupt,
  output logic               overflow
);

  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_dout;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_drop;
  logic             w_txrdy_rise;
  logic [K_WIDTH-1:0] w_keff;

  tx_state_t          r_state;
  logic               r_tx;
  logic [K_WIDTH-1:0] r_cnt;
  logic [K_WIDTH-1:0] r_keff;
  logic [7:0]         r_shift;
  logic [2:0]         r_bits_left;
  logic               r_eight;
  logic               r_pen;
  logic               r_stop2;
  logic               r_par;
  logic               r_txrdy;
  logic               r_txrdy_d;
  logic               r_int;
  logic               r_ovf;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (write),
    .din   (din),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_drop = write && w_full && !w_pop;
  assign w_keff = (k < K_WIDTH'(KMIN)) ? K_WIDTH'(KMIN) : k;

  // Every non-idle state holds tx for r_keff cycles via the down-counter;
  // tx is registered so the line changes exactly on the state transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_cnt       <= '0;
      r_keff      <= K_WIDTH'(KMIN);
      r_shift     <= '0;
      r_bits_left <= '0;
      r_eight     <= 1'b1;
      r_pen       <= 1'b0;
      r_stop2     <= 1'b0;
      r_par       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_state <= START;
            r_tx    <= 1'b0;
            r_shift <= w_dout;
            r_keff  <= w_keff;
            r_cnt   <= w_keff - K_WIDTH'(1);
            r_eight <= eight;
            r_pen   <= pen;
            r_stop2 <= stop2;
            r_par   <= parity_bit(w_dout, eight, ohel);
          end
        end
        default: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - K_WIDTH'(1);
          end else begin
            r_cnt <= r_keff - K_WIDTH'(1);
            case (r_state)
              START: begin
                r_state     <= DATA;
                r_tx        <= r_shift[0];
                // bits still to send after the one now on the line
                r_bits_left <= r_eight ? 3'd7 : 3'd6;
              end
              DATA: begin
                if (r_bits_left != 3'd0) begin
                  r_shift     <= {1'b0, r_shift[7:1]};
                  r_tx        <= r_shift[1];
                  r_bits_left <= r_bits_left - 3'd1;
                end else if (r_pen) begin
                  r_state <= PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= STOP1;
                  r_tx    <= 1'b1;
                end
              end
              PARITY: begin
                r_state <= STOP1;
                r_tx    <= 1'b1;
              end
              STOP1: begin
                r_state <= r_stop2 ? STOP2 : IDLE;
                r_tx    <= 1'b1;
              end
              default: begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // txrdy resets high; the delayed copy also resets high so reset itself
  // never looks like a rising edge.
  assign w_txrdy_rise = r_txrdy && !r_txrdy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_txrdy   <= 1'b1;
      r_txrdy_d <= 1'b1;
      r_int     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_txrdy   <= (w_count != CNT_W'(FIFO_DEPTH));
      r_txrdy_d <= r_txrdy;
      if (w_txrdy_rise) r_int <= 1'b1;
      else if (int_ack) r_int <= 1'b0;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
    end
  end

  assign tx         = r_tx;
  assign txrdy      = r_txrdy;
  assign fifo_empty = w_empty;
  assign fifo_count = w_count;
  assign busy       = (r_state != IDLE);
  assign interrupt  = r_int;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int DEPTH = 4;
  localparam int KW    = 19;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          eight = 1'b1;
  logic          pen = 1'b0;
  logic          ohel = 1'b0;
  logic          stop2 = 1'b0;
  logic [KW-1:0] k = KW'(4);
  logic          int_ack = 1'b0;
  logic          clr_err = 1'b0;

  logic          tx;
  logic          txrdy;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          interrupt;
  logic          overflow;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .FIFO_DEPTH (DEPTH),
    .K_WIDTH    (KW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .din        (din),
    .eight      (eight),
    .pen        (pen),
    .ohel       (ohel),
    .stop2      (stop2),
    .k          (k),
    .int_ack    (int_ack),
    .clr_err    (clr_err),
    .tx         (tx),
    .txrdy      (txrdy),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .busy       (busy),
    .interrupt  (interrupt),
    .overflow   (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued bytes plus the remaining per-cycle line levels
  // of the frame being sent.
  logic [7:0] m_q[$];
  bit         m_line[$];
  bit m_tx = 1'b1, m_busy = 1'b0, m_txrdy = 1'b1, m_txrdy_d = 1'b1;
  bit m_int = 1'b0, m_ovf = 1'b0;

  function automatic void build_frame(input logic [7:0] d);
    int keff, nbits, ones;
    bit b[$];
    keff  = (k < 2) ? 2 : int'(k);
    nbits = eight ? 8 : 7;
    ones  = 0;
    b.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) b.push_back(ohel ? ((ones % 2) == 0) : ((ones % 2) == 1));
    b.push_back(1'b1);
    if (stop2) b.push_back(1'b1);
    foreach (b[i]) for (int c = 0; c < keff; c++) m_line.push_back(b[i]);
  endfunction

  task automatic model_step();
    int  pre_size;
    bit  did_pop, drop, new_txrdy, rise;
    if (!rst) begin
      m_q.delete(); m_line.delete();
      m_tx = 1; m_busy = 0; m_txrdy = 1; m_txrdy_d = 1; m_int = 0; m_ovf = 0;
      return;
    end
    pre_size  = m_q.size();
    did_pop   = 0;
    drop      = 0;
    new_txrdy = (pre_size != DEPTH);
    rise      = m_txrdy && !m_txrdy_d;
    if (m_line.size() > 0) begin
      m_tx = m_line.pop_front(); m_busy = 1;
    end else if (!m_busy && pre_size > 0) begin
      build_frame(m_q.pop_front());
      m_tx = m_line.pop_front(); m_busy = 1; did_pop = 1;
    end else begin
      m_tx = 1; m_busy = 0;
    end
    if (write) begin
      if (pre_size < DEPTH || did_pop) m_q.push_back(din);
      else drop = 1;
    end
    m_ovf     = drop ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_int     = rise ? 1'b1 : (int_ack ? 1'b0 : m_int);
    m_txrdy_d = m_txrdy;
    m_txrdy   = new_txrdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("tx",        32'(tx),         32'(m_tx));
    check("busy",      32'(busy),       32'(m_busy));
    check("count",     32'(fifo_count), 32'(m_q.size()));
    check("empty",     32'(fifo_empty), 32'(m_q.size() == 0));
    check("txrdy",     32'(txrdy),      32'(m_txrdy));
    check("interrupt", 32'(interrupt),  32'(m_int));
    check("overflow",  32'(overflow),   32'(m_ovf));
  endtask

  logic samp [64];
  int   busy_cnt;

  task automatic capture(input int n);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      samp[i] = tx;
      busy_cnt += int'(busy);
    end
  endtask

  task automatic wait_txrdy(input logic val, input string tag);
    int t;
    t = 0;
    while (txrdy !== val && t < 4000) begin
      cyc();
      t++;
    end
    check(tag, 32'(txrdy), 32'(val));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || !fifo_empty) && t < 4000) begin
      cyc();
      t++;
    end
    check("drain", 32'(busy || !fifo_empty), 32'd0);
  endtask

  initial begin
    logic exp_a5 [10];
    logic exp_41 [11];
    int   zeros;
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset
    #1;
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("rst_tx",    32'(tx),         32'd1);
    check("rst_txrdy", 32'(txrdy),      32'd1);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_int",   32'(interrupt),  32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);

    // 8N1, k=4, 0xA5
    k = KW'(4); eight = 1; pen = 0; stop2 = 0;
    din = 8'hA5; write = 1; cyc(); write = 0;
    check("a5_pre_fall", 32'(tx), 32'd1);
    capture(45);
    for (int j = 0; j < 10; j++) begin
      check("a5_bit_first", 32'(samp[4*j]),   32'(exp_a5[j]));
      check("a5_bit_last",  32'(samp[4*j+3]), 32'(exp_a5[j]));
    end
    check("a5_busy_cycles", 32'(busy_cnt), 32'd40);

    // 7 bits, parity, 2 stop, 0x41: even then odd
    eight = 0; pen = 1; ohel = 0; stop2 = 1;
    din = 8'h41; write = 1; cyc(); write = 0;
    capture(46);
    for (int j = 0; j < 11; j++) check("41e_bit", 32'(samp[4*j+1]), 32'(exp_41[j]));
    check("41e_busy_cycles", 32'(busy_cnt), 32'd44);
    ohel = 1;
    din = 8'h41; write = 1; cyc(); write = 0;
    capture(46);
    check("41o_parity", 32'(samp[4*8+2]), 32'd1);
    check("41o_stop2",  32'(samp[4*10+2]), 32'd1);

    // overflow: 6 back-to-back writes into a depth-4 FIFO, k=100
    k = KW'(100); eight = 1; pen = 0; ohel = 0; stop2 = 0;
    for (int i = 0; i < 6; i++) begin
      din = 8'($urandom); write = 1; cyc();
    end
    write = 0;
    k = KW'(4);
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_txrdy", 32'(txrdy),      32'd0);
    check("ovf_set",   32'(overflow),   32'd1);
    din = 8'h3C; write = 1; clr_err = 1; cyc();
    write = 0;
    check("ovf_set_beats_clr", 32'(overflow), 32'd1);
    cyc();
    clr_err = 0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // interrupt on txrdy rising edge, then ack collision
    wait_txrdy(1'b1, "txrdy_rise1");
    check("int_latency", 32'(interrupt), 32'd0);
    cyc();
    check("int_set", 32'(interrupt), 32'd1);
    int_ack = 1; cyc(); int_ack = 0;
    check("int_ack_clear", 32'(interrupt), 32'd0);
    din = 8'h5A; write = 1; cyc(); write = 0;
    wait_txrdy(1'b0, "txrdy_fall2");
    wait_txrdy(1'b1, "txrdy_rise2");
    int_ack = 1; cyc(); int_ack = 0;
    check("int_set_beats_ack", 32'(interrupt), 32'd1);
    int_ack = 1; cyc(); int_ack = 0;
    check("int_lone_ack", 32'(interrupt), 32'd0);
    wait_idle();

    // k=0 clamps to 2; reset mid-DATA abandons the frame and the queue
    k = '0; eight = 1; pen = 0; stop2 = 0;
    din = 8'h01; write = 1; cyc();
    din = 8'h55; cyc();
    write = 0;
    check("k0_start_a", 32'(tx), 32'd0);
    cyc();
    check("k0_start_b", 32'(tx), 32'd0);
    cyc();
    check("k0_d0", 32'(tx), 32'd1);
    cyc();
    check("k0_d0_hold", 32'(tx), 32'd1);
    cyc();
    check("k0_d1", 32'(tx), 32'd0);
    rst = 0; cyc(); rst = 1;
    check("mid_rst_tx",    32'(tx),         32'd1);
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check("mid_rst_busy",  32'(busy),       32'd0);
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (tx == 1'b0) zeros++;
    end
    check("mid_rst_no_start", 32'(zeros), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      write   = ($urandom_range(0, 11) == 0);
      din     = 8'($urandom);
      k       = KW'($urandom_range(0, 5));
      int_ack = ($urandom_range(0, 7) == 0);
      clr_err = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 19) == 0) begin
        eight = 1'($urandom); pen = 1'($urandom);
        ohel  = 1'($urandom); stop2 = 1'($urandom);
      end
      cyc();
    end
    write = 0; int_ack = 0; clr_err = 0; rst = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised successor to the single-byte UART transmit engine. A write-strobed sync FIFO feeds a transmit FSM that supports 7/8 data bits, optional odd or even parity, and 1 or 2 stop bits. The block also owns TXRDY edge detection and the interrupt set/ack flop, and sits between the address decoder's write strobe and the TX pin.

Parameters:
FIFO_DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
K_WIDTH, 19, width of the baud divisor input k.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  reset, synchronous, active-low.
write  in  1  one-cycle strobe; pushes din into the FIFO.
din  in  8  byte to transmit; bit 7 is ignored when eight=0.
eight  in  1  1 = 8 data bits, 0 = 7 data bits.
pen  in  1  parity enable.
ohel  in  1  parity sense: 1 = odd, 0 = even.
stop2  in  1  1 = two stop bits.
k  in  K_WIDTH  bit period in clk cycles.
int_ack  in  1  clears interrupt.
clr_err  in  1  clears overflow.
tx  out  1  serial line; idles high.
txrdy  out  1  FIFO not full.
fifo_empty  out  1  FIFO holds no entries.
fifo_count  out  CNT_W  current occupancy.
busy  out  1  FSM is not in IDLE.
interrupt  out  1  transmitter-ready interrupt request.
overflow  out  1  sticky; set when a write arrives while the FIFO is full.

Behaviour:
- Reset (rst=0 at a clk edge): tx=1, txrdy=1, fifo_empty=1, fifo_count=0, busy=0, interrupt=0, overflow=0. The FSM returns to IDLE and the FIFO pointers clear. A frame in progress is abandoned, and tx is high on the first cycle after the reset edge.
- Bit period: an effective divisor keff = max(k,2) is computed. Each serial bit holds tx for exactly keff cycles. k is sampled at the frame start and held for the whole frame.
- Mode latch: eight, pen, ohel and stop2 are captured when the FSM leaves IDLE. Changes during a frame take effect on the next frame.
- FSM states are IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for keff cycles, then DATA.
  - DATA: send LSB first; 8 or 7 bits. After the last bit go to PARITY if pen=1, else STOP1.
  - PARITY: the parity bit is the XOR of the sent data bits, XORed with ohel, so that the total count of ones is even (ohel=0) or odd (ohel=1). Then STOP1.
  - STOP1: tx=1 for keff cycles. Then STOP2 if stop2=1, else IDLE.
  - STOP2: tx=1 for keff cycles, then IDLE.
- Back-to-back frames: on the cycle the FSM returns to IDLE with the FIFO non-empty, it pops immediately. This gives exactly one idle cycle between the last stop bit and the next start bit.
- Latency: for a write sampled at edge N into an empty FIFO with the FSM idle, the FIFO updates at N, the FSM pops at N+1, and tx=0 is visible after edge N+1.
- FIFO rules:
  - A push when full is dropped and sets overflow.
  - When full, a simultaneous push and pop are both accepted and the count is unchanged.
  - When empty, a simultaneous push and pop cannot happen because a pop requires non-empty in the registered state.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set has priority over clr_err when both occur in the same cycle.
- txrdy = (fifo_count != FIFO_DEPTH), registered.
- Interrupt: a rising-edge detect on txrdy, registered with one cycle of latency, sets interrupt. int_ack clears it. If set and ack occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP1, STOP2);
  - PAR_EVEN=0 and PAR_ODD=1;
  - the minimum divisor KMIN=2.
- Sub-module sync_fifo, parametrised by WIDTH=8 and DEPTH. It provides push, pop, dout, full, empty and count.
- The FSM, baud counter, parity logic, edge detect and SR flops live in uart_tx_buffered.

Test Plan:
1. Reset: hold rst=0 for 3 cycles, then release → tx=1, txrdy=1, fifo_empty=1, interrupt=0, overflow=0.
2. 8N1 framing: k=4, eight=1, pen=0, stop2=0, write 0xA5 → tx emits 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx falls 2 cycles after the write; busy is high for 40 cycles.
3. 7-bit parity, even: k=4, eight=0, pen=1, ohel=0, stop2=1, din=0x41 → tx emits start 0; data 1,0,0,0,0,0,1; parity 0; stop 1,1. With ohel=1 the parity bit is 1.
4. Overflow and simultaneous events: with FIFO_DEPTH=4, k=100, write 6 bytes in consecutive cycles → the first byte is popped, the FIFO fills to 4, txrdy=0, overflow=1, and one byte is lost. Asserting clr_err together with another write while full keeps overflow=1.
5. Interrupt: with the FIFO full, wait until a pop makes txrdy go 0→1 → interrupt=1 one cycle later. Asserting int_ack on the same cycle as a new set edge leaves interrupt=1; a lone ack gives interrupt=0.
6. k clamp and mid-frame reset: with k=0, bits are held 2 cycles. Dropping rst mid-DATA gives tx=1 next cycle, the FIFO empty, and no further start bit.
